// File: rtl/sad_column_feeder.sv
// sad_column_feeder
//   Builds KERNEL_WIDTH-tall vertical pixel columns for the left and right eye
//   from a raster pixel stream. It queues the columns in a FIFO and issues them
//   one at a time to a SAD matcher, waiting whenever the matcher reports busy.
//
// Optional feature:
//   SAD_FEEDER_DROP_COUNT_EN - when defined, drop_count_out counts the columns
//   discarded on FIFO overflow and saturates at 16'hFFFF. When undefined,
//   drop_count_out is tied to zero.
//
// Ports:
//   clk_in, rst_n_in               clock and asynchronous active-low reset
//   left/right_pixel_in [7:0]      grayscale pixels at (hcount_in, vcount_in)
//   hcount_in [10:0], vcount_in [9:0]  input pixel coordinates
//   pixel_valid_in                 qualifies the pixel inputs
//   sad_busy_in                    matcher busy; no column is issued while high
//   left/right_col_out             [0] = oldest row, [KERNEL_WIDTH-1] = newest row
//   hcount_out, vcount_out         coordinates of the newest pixel in the column
//   data_valid_out                 one-cycle strobe presenting a column
//   fifo_count_out                 current FIFO occupancy
//   drop_count_out                 number of discarded columns
module sad_column_feeder #(
    parameter int KERNEL_WIDTH = 3,
    parameter int LINE_WIDTH   = 320,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic [7:0]                         left_pixel_in,
    input  logic [7:0]                         right_pixel_in,
    input  logic [10:0]                        hcount_in,
    input  logic [9:0]                         vcount_in,
    input  logic                               pixel_valid_in,
    input  logic                               sad_busy_in,
    output logic [KERNEL_WIDTH-1:0][7:0]       left_col_out,
    output logic [KERNEL_WIDTH-1:0][7:0]       right_col_out,
    output logic [10:0]                        hcount_out,
    output logic [9:0]                         vcount_out,
    output logic                               data_valid_out,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count_out,
    output logic [15:0]                        drop_count_out
);

    localparam int unsigned NBUF = KERNEL_WIDTH - 1;
    localparam int LAW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int PAW = $clog2(FIFO_DEPTH);
    localparam int CW  = KERNEL_WIDTH * 8;
    localparam int EW  = 2 * CW + 21;
    localparam logic [11:0]  LINE_W12  = 12'(LINE_WIDTH);
    localparam logic [9:0]   FIRST_ROW = 10'(KERNEL_WIDTH - 1);
    localparam logic [PAW:0] FULL_CNT  = (PAW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    // ------------------------------------------------------------------
    // Line buffers and column forming
    // ------------------------------------------------------------------
    logic [7:0] lbuf_l [NBUF][LINE_WIDTH];
    logic [7:0] lbuf_r [NBUF][LINE_WIDTH];

    logic                          accept;
    logic [LAW-1:0]                addr;
    logic [KERNEL_WIDTH-1:0][7:0]  col_l_d, col_r_d;

    assign accept = pixel_valid_in && ({1'b0, hcount_in} < LINE_W12);
    assign addr   = hcount_in[LAW-1:0];

    always_comb begin
        col_l_d = '0;
        col_r_d = '0;
        for (int unsigned k = 0; k < NBUF; k++) begin
            col_l_d[k] = lbuf_l[k][addr];
            col_r_d[k] = lbuf_r[k][addr];
        end
        col_l_d[KERNEL_WIDTH-1] = left_pixel_in;
        col_r_d[KERNEL_WIDTH-1] = right_pixel_in;
    end

    // Each buffer row takes the row below it, so the buffers always hold the
    // newest KERNEL_WIDTH-1 rows seen at this hcount.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int unsigned k = 0; k < NBUF; k++) begin
                lbuf_l[k][addr] <= col_l_d[k+1];
                lbuf_r[k][addr] <= col_r_d[k+1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Column stage register (feeds the FIFO one edge after acceptance)
    // ------------------------------------------------------------------
    logic                          stg_vld_q;
    logic [KERNEL_WIDTH-1:0][7:0]  stg_l_q, stg_r_q;
    logic [10:0]                   stg_h_q;
    logic [9:0]                    stg_v_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stg_vld_q <= 1'b0;
            stg_l_q   <= '0;
            stg_r_q   <= '0;
            stg_h_q   <= '0;
            stg_v_q   <= '0;
        end else begin
            stg_vld_q <= accept && (vcount_in >= FIRST_ROW);
            if (accept) begin
                stg_l_q <= col_l_d;
                stg_r_q <= col_r_d;
                stg_h_q <= hcount_in;
                stg_v_q <= vcount_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Column FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PAW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PAW:0]   count_q;
    state_t         state_q, state_d;
    logic           full, empty, pop, push_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop     = (state_q == IDLE) && !empty && !sad_busy_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = stg_vld_q && (!full || pop);

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= {stg_l_q, stg_r_q, stg_h_q, stg_v_q};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers (change only on a pop)
    // ------------------------------------------------------------------
    logic [KERNEL_WIDTH-1:0][7:0]  out_l_q, out_r_q;
    logic [10:0]                   out_h_q;
    logic [9:0]                    out_v_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_l_q <= '0;
            out_r_q <= '0;
            out_h_q <= '0;
            out_v_q <= '0;
        end else if (pop) begin
            {out_l_q, out_r_q, out_h_q, out_v_q} <= fifo_mem[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: IDLE -> ISSUE (strobe) -> HOLD (matcher raises busy) -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = ISSUE;
            ISSUE:   state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_valid_out = (state_q == ISSUE);
    end

    assign left_col_out   = out_l_q;
    assign right_col_out  = out_r_q;
    assign hcount_out     = out_h_q;
    assign vcount_out     = out_v_q;
    assign fifo_count_out = count_q;

    // ------------------------------------------------------------------
    // Drop counter
    // ------------------------------------------------------------------
`ifdef SAD_FEEDER_DROP_COUNT_EN
    logic        drop;
    logic [15:0] drop_q;

    assign drop = stg_vld_q && full && !pop;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                     drop_q <= '0;
        else if (drop && (drop_q != '1))   drop_q <= drop_q + 1'b1;
    end

    assign drop_count_out = drop_q;
`else
    assign drop_count_out = '0;
`endif

endmodule

// File: tb/tb_sad_column_feeder.sv
module tb_sad_column_feeder;

    localparam int K  = 3;
    localparam int LW = 320;
    localparam int FD = 16;
`ifdef SAD_FEEDER_DROP_COUNT_EN
    localparam int EXP_DROP = 4;
`else
    localparam int EXP_DROP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        left_pixel, right_pixel;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              pixel_valid;
    logic              sad_busy;
    logic [K-1:0][7:0] left_col, right_col;
    logic [10:0]       hcount_o;
    logic [9:0]        vcount_o;
    logic              data_valid;
    logic [$clog2(FD):0] fifo_count;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    sad_column_feeder #(
        .KERNEL_WIDTH (K),
        .LINE_WIDTH   (LW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .left_pixel_in  (left_pixel),
        .right_pixel_in (right_pixel),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .pixel_valid_in (pixel_valid),
        .sad_busy_in    (sad_busy),
        .left_col_out   (left_col),
        .right_col_out  (right_col),
        .hcount_out     (hcount_o),
        .vcount_out     (vcount_o),
        .data_valid_out (data_valid),
        .fifo_count_out (fifo_count),
        .drop_count_out (drop_count)
    );

    typedef struct {
        logic [10:0]       h;
        logic [9:0]        v;
        logic [K-1:0][7:0] l;
        logic [K-1:0][7:0] r;
        bit                known;
    } col_t;

    // Reference model: per-hcount history of accepted pixels (oldest first)
    // and the ordered list of columns the DUT is expected to issue.
    logic [7:0] hist_l [LW][$];
    logic [7:0] hist_r [LW][$];
    col_t       exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int strobes  = 0;
    int strobe_cycles[$];
    bit chk35    = 0;
    bit seen35   = 0;

    task automatic check_bits(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        col_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (data_valid === 1'b1) begin
            strobes++;
            strobe_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                check_bits("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_bits("col_hcount", 64'(hcount_o), 64'(e.h));
                check_bits("col_vcount", 64'(vcount_o), 64'(e.v));
                if (e.known) begin
                    check_bits("col_left", 64'(left_col), 64'(e.l));
                    check_bits("col_right", 64'(right_col), 64'(e.r));
                end
            end
            if (chk35 && hcount_o == 11'd5 && vcount_o == 10'd2) begin
                seen35 = 1;
                check_bits("req35_left_col", 64'(left_col), 64'h251505);
            end
        end
    endtask

    task automatic drive(input int h, input int v, input logic [7:0] l, input logic [7:0] r, input bit valid);
        col_t e;
        hcount      = 11'(h);
        vcount      = 10'(v);
        left_pixel  = l;
        right_pixel = r;
        pixel_valid = valid;
        if (valid && h < LW) begin
            hist_l[h].push_back(l);
            hist_r[h].push_back(r);
            if (hist_l[h].size() > K) begin
                void'(hist_l[h].pop_front());
                void'(hist_r[h].pop_front());
            end
            if (v >= K - 1) begin
                e.h = 11'(h);
                e.v = 10'(v);
                e.known = (hist_l[h].size() == K);
                e.l = '0;
                e.r = '0;
                if (e.known) begin
                    for (int i = 0; i < K; i++) begin
                        e.l[i] = hist_l[h][i];
                        e.r[i] = hist_r[h][i];
                    end
                end
                exp_q.push_back(e);
            end
        end
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_bits("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        check_bits("drain_fifo_count", 64'(fifo_count), 64'd0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        for (int h = 0; h < LW; h++) begin
            hist_l[h].delete();
            hist_r[h].delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n       = 1'b0;
        left_pixel  = '0;
        right_pixel = '0;
        hcount      = '0;
        vcount      = '0;
        pixel_valid = 1'b0;
        sad_busy    = 1'b0;

        // Reset state
        #12;
        check_bits("rst_valid", 64'(data_valid), 64'd0);
        check_bits("rst_fifo_count", 64'(fifo_count), 64'd0);
        check_bits("rst_drop_count", 64'(drop_count), 64'd0);
        check_bits("rst_hcount", 64'(hcount_o), 64'd0);
        check_bits("rst_vcount", 64'(vcount_o), 64'd0);
        check_bits("rst_left_col", 64'(left_col), 64'd0);
        check_bits("rst_right_col", 64'(right_col), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // First rows only fill the buffers; row 2 produces columns
        chk35 = 1;
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < 8; h++) begin
                drive(h, v, 8'(v * 16 + h), 8'($urandom), 1'b1);
            end
            if (v == 1) check_bits("req35_no_strobe_rows01", 64'(strobes), 64'd0);
        end
        drain(100);
        check_bits("req35_seen", 64'(seen35), 64'd1);
        chk35 = 0;

        // Minimum latency: strobe exactly 3 edges after acceptance
        drive(7, 2, 8'hA7, 8'h3C, 1'b1);
        check_bits("lat_edge1", 64'(data_valid), 64'd0);
        tick();
        check_bits("lat_edge2", 64'(data_valid), 64'd0);
        tick();
        check_bits("lat_edge3", 64'(data_valid), 64'd1);
        check_bits("lat_hcount", 64'(hcount_o), 64'd7);
        check_bits("lat_vcount", 64'(vcount_o), 64'd2);
        tick();
        check_bits("lat_edge4", 64'(data_valid), 64'd0);
        drain(20);

        // Randomized traffic, including ignored pixels (invalid / h >= LINE_WIDTH)
        for (int i = 0; i < 300; i++) begin
            sad_busy = ($urandom_range(0, 7) == 0);
            drive(296 + $urandom_range(0, 31), $urandom_range(0, 5),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            repeat (4) begin
                sad_busy = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        sad_busy = 1'b0;
        drain(300);
        check_bits("rand_drop_count", 64'(drop_count), 64'd0);

        // Overflow: 20 columns while busy, last 4 discarded
        sad_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(100 + i, 2, 8'(i), 8'(255 - i), 1'b1);
        end
        tick();
        repeat (4) void'(exp_q.pop_back());
        check_bits("ovf_fifo_count", 64'(fifo_count), 64'd16);
        check_bits("ovf_drop_count", 64'(drop_count), 64'(EXP_DROP));

        // Full FIFO: push and pop on the same edge
        drive(200, 2, 8'h11, 8'h22, 1'b1);
        sad_busy = 1'b0;
        tick();
        check_bits("pushpop_valid", 64'(data_valid), 64'd1);
        check_bits("pushpop_fifo_count", 64'(fifo_count), 64'd16);
        check_bits("pushpop_drop_count", 64'(drop_count), 64'(EXP_DROP));
        drain(200);

        // Back-to-back issue cadence with 3 queued columns
        sad_busy = 1'b1;
        for (int i = 0; i < 3; i++) drive(10 + i, 3, 8'($urandom), 8'($urandom), 1'b1);
        tick();
        strobe_cycles.delete();
        sad_busy = 1'b0;
        for (int n = 0; n < 50 && strobe_cycles.size() < 3; n++) tick();
        check_bits("cadence_count", 64'(strobe_cycles.size()), 64'd3);
        if (strobe_cycles.size() == 3) begin
            check_bits("cadence_gap1", 64'(strobe_cycles[1] - strobe_cycles[0]), 64'd3);
            check_bits("cadence_gap2", 64'(strobe_cycles[2] - strobe_cycles[1]), 64'd3);
        end
        drain(20);

        // Reset mid-operation with 5 queued columns
        sad_busy = 1'b1;
        for (int i = 0; i < 5; i++) drive(20 + i, 4, 8'($urandom), 8'($urandom), 1'b1);
        tick();
        check_bits("midrst_pre_count", 64'(fifo_count), 64'd5);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_bits("midrst_async_count", 64'(fifo_count), 64'd0);
        check_bits("midrst_async_valid", 64'(data_valid), 64'd0);
        @(posedge clk);
        #3;
        rst_n    = 1'b1;
        sad_busy = 1'b0;
        s0 = strobes;
        repeat (10) tick();
        check_bits("midrst_no_strobe", 64'(strobes - s0), 64'd0);
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < 2; h++) drive(h, v, 8'($urandom), 8'($urandom), 1'b1);
        end
        drain(30);
        check_bits("midrst_new_strobes", 64'(strobes - s0), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
